branch_resolver: RTL and testbench
==================================

# branch_resolver

Commit-side branch resolution unit: the producer end of the branch-forwarding interface consumed by the PC unit. Compares each committed control-transfer instruction's prediction against its actual outcome, emits the forwarding record (misbranch, taken, branch PC, correct address), and holds off further commits for a fixed flush window after a misbranch so the pipeline can roll back. Keeps wrap-around branch and mispredict counters for performance debug.

## Interface
- FLUSH_CYCLES, 2, cycles out_ready stays low after a misbranch pulse (≥1)
- CNT_WIDTH, 32, width of statistics counters
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  global enable; when low, state and counters freeze
- in_commit_valid  in  1  ROB head presents an instruction this cycle
- in_commit_is_branch  in  1  conditional branch (BRANCH_OP)
- in_commit_is_jalr  in  1  JALR (always predicted pc+4)
- in_commit_pc  in  32  instruction PC
- in_commit_pred_taken  in  1  taken prediction made at fetch
- in_commit_actual_taken  in  1  resolved outcome (ignored for JALR)
- in_commit_target  in  32  resolved taken target (branch) or jump target (JALR)
- out_ready  out  1  resolver accepts a commit this cycle
- out_misbranch  out  1  one-cycle misbranch pulse
- out_branch_taken  out  1  actual outcome of the reported instruction
- out_branch_pc  out  32  PC of the reported instruction
- out_correct_address  out  32  address fetch must resume from
- out_update_valid  out  1  one-cycle pulse, predictor-update record valid
- out_branch_count  out  CNT_WIDTH  resolved control transfers
- out_mispredict_count  out  CNT_WIDTH  misbranches issued

## Operation
- Accept: in_commit_valid & out_ready & ena & (is_branch | is_jalr) at a rising edge. Non-control commits are ignored (no pulses, no count).
- Branch: correct = actual_taken ? target : pc+4; misbranch = pred_taken != actual_taken.
- JALR: taken = 1; correct = target; misbranch = (target != pc+4).
- Both is_branch and is_jalr high: treat as JALR.
- Additions are 32-bit modulo; pc+4 wraps at 2^32.
- On accept: out_update_valid=1 next cycle; out_branch_taken/pc/correct_address latched; out_branch_count += 1; if misbranch: out_misbranch=1 next cycle, out_mispredict_count += 1, FSM → FLUSH.
- Latched record fields hold until next accept.
- Counters wrap to 0 on overflow.
- FSM states: IDLE (out_ready=1), FLUSH (out_ready=0, down-counter loaded with FLUSH_CYCLES on entry, decrements each enabled cycle, → IDLE when it reaches 1 and decrements).
- In FLUSH, all commits are ignored (ROB must hold them; out_ready=0 signals stall).
- ena=0: no accept, FSM/counter/statistics hold; pulse outputs are 0 on the following cycle.

## Timing
- Reset values: out_ready=1 (IDLE), out_misbranch=0, out_update_valid=0, out_branch_taken=0, out_branch_pc=0, out_correct_address=0, both counters=0, flush counter=0.
- All outputs registered; latency from accepting edge to record/pulses = 1 cycle.
- out_ready is a registered state decode: low on the cycle out_misbranch is high, remains low exactly FLUSH_CYCLES cycles (enabled cycles), high on the next.
- Back-to-back correct predictions: one accept per cycle, out_update_valid high continuously.
- Reset mid-FLUSH: IDLE next cycle, pulses cleared, counters zeroed.

## Test plan
- Reset: rst=1 two cycles → out_ready=1, all outputs and counters 0.
- Correct branch: pc=0x100, pred=0, actual=0, target=0x140 → next cycle update_valid=1, misbranch=0, taken=0, correct_address=0x104, branch_count=1.
- Mispredicted branch: pc=0x200, pred=0, actual=1, target=0x180 → misbranch=1 one cycle, correct_address=0x180, mispredict_count=1; out_ready low exactly 2 cycles; a commit offered during flush is not counted.
- JALR: pc=0x300, target=0x304 → no misbranch, taken=1; target=0x400 → misbranch=1, correct_address=0x400.
- Wrap/edge: pc=0xFFFFFFFC, branch not taken correctly predicted → correct_address=0x00000000; counters preset near max via 2^CNT_WIDTH accepts with CNT_WIDTH=4 → wrap to 0.
- ena/reset interplay: ena=0 during flush extends stall by held cycles; rst asserted in FLUSH → out_ready=1 next cycle, counters 0.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Branch-forwarding interface between the commit stage (ROB head) and the branch resolver.
// The master side presents committed instructions; the slave side (the resolver) returns the
// forwarding record, the stall indication and the statistics counters.
interface branch_resolver_if #(
   parameter int unsigned CNT_WIDTH = 32
) ();
   logic                 in_commit_valid;
   logic                 in_commit_is_branch;
   logic                 in_commit_is_jalr;
   logic [31:0]          in_commit_pc;
   logic                 in_commit_pred_taken;
   logic                 in_commit_actual_taken;
   logic [31:0]          in_commit_target;
   logic                 out_ready;
   logic                 out_misbranch;
   logic                 out_branch_taken;
   logic [31:0]          out_branch_pc;
   logic [31:0]          out_correct_address;
   logic                 out_update_valid;
   logic [CNT_WIDTH-1:0] out_branch_count;
   logic [CNT_WIDTH-1:0] out_mispredict_count;

   modport master (
      output in_commit_valid, in_commit_is_branch, in_commit_is_jalr, in_commit_pc,
             in_commit_pred_taken, in_commit_actual_taken, in_commit_target,
      input  out_ready, out_misbranch, out_branch_taken, out_branch_pc, out_correct_address,
             out_update_valid, out_branch_count, out_mispredict_count
   );

   modport slave (
      input  in_commit_valid, in_commit_is_branch, in_commit_is_jalr, in_commit_pc,
             in_commit_pred_taken, in_commit_actual_taken, in_commit_target,
      output out_ready, out_misbranch, out_branch_taken, out_branch_pc, out_correct_address,
             out_update_valid, out_branch_count, out_mispredict_count
   );
endinterface

// File: rtl/branch_resolver.sv
// Commit-side branch resolution: checks each committed branch/JALR against its prediction,
// publishes the forwarding record one cycle later, and stalls commit for a fixed flush window
// after a misbranch so the pipeline can roll back.
module branch_resolver #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input logic              clk,
   input logic              rst,
   input logic              ena,
   branch_resolver_if.slave br_if
);
   localparam int unsigned FcW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [0:0] {StIdle, StFlush} state_e;

   state_e               r_state;
   logic [FcW-1:0]       r_flush_cnt;
   logic                 r_ready;
   logic                 r_misbranch;
   logic                 r_update_valid;
   logic                 r_branch_taken;
   logic [31:0]          r_branch_pc;
   logic [31:0]          r_correct_address;
   logic [CNT_WIDTH-1:0] r_branch_count;
   logic [CNT_WIDTH-1:0] r_mispredict_count;

   logic                 w_is_ctrl;
   logic                 w_accept;
   logic [31:0]          w_pc_plus4;
   logic                 w_taken;
   logic [31:0]          w_correct;
   logic                 w_mis;

   // Resolve the instruction at the ROB head; JALR wins when both type flags are set.
   always_comb begin
      w_is_ctrl  = br_if.in_commit_is_branch | br_if.in_commit_is_jalr;
      w_accept   = ena & br_if.in_commit_valid & r_ready & w_is_ctrl;
      w_pc_plus4 = br_if.in_commit_pc + 32'd4;
      if (br_if.in_commit_is_jalr) begin
         w_taken   = 1'b1;
         w_correct = br_if.in_commit_target;
         w_mis     = (br_if.in_commit_target != w_pc_plus4);
      end else begin
         w_taken   = br_if.in_commit_actual_taken;
         w_correct = br_if.in_commit_actual_taken ? br_if.in_commit_target : w_pc_plus4;
         w_mis     = (br_if.in_commit_pred_taken != br_if.in_commit_actual_taken);
      end
   end

   // Resolver FSM with registered record, pulses, flush countdown and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state            <= StIdle;
         r_flush_cnt        <= '0;
         r_ready            <= 1'b1;
         r_misbranch        <= 1'b0;
         r_update_valid     <= 1'b0;
         r_branch_taken     <= 1'b0;
         r_branch_pc        <= '0;
         r_correct_address  <= '0;
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         // Pulses last one cycle and are also cleared while disabled.
         r_misbranch    <= 1'b0;
         r_update_valid <= 1'b0;
         if (ena) begin
            unique case (r_state)
               StIdle: begin
                  if (w_accept) begin
                     r_update_valid    <= 1'b1;
                     r_branch_taken    <= w_taken;
                     r_branch_pc       <= br_if.in_commit_pc;
                     r_correct_address <= w_correct;
                     r_branch_count    <= r_branch_count + CNT_WIDTH'(1);
                     if (w_mis) begin
                        r_misbranch        <= 1'b1;
                        r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
                        r_state            <= StFlush;
                        r_ready            <= 1'b0;
                        r_flush_cnt        <= FcW'(FLUSH_CYCLES);
                     end
                  end
               end
               StFlush: begin
                  if (r_flush_cnt == FcW'(1)) begin
                     r_state     <= StIdle;
                     r_ready     <= 1'b1;
                     r_flush_cnt <= '0;
                  end else begin
                     r_flush_cnt <= r_flush_cnt - FcW'(1);
                  end
               end
               default: begin
                  r_state <= StIdle;
                  r_ready <= 1'b1;
               end
            endcase
         end
      end
   end

   assign br_if.out_ready            = r_ready;
   assign br_if.out_misbranch        = r_misbranch;
   assign br_if.out_update_valid     = r_update_valid;
   assign br_if.out_branch_taken     = r_branch_taken;
   assign br_if.out_branch_pc        = r_branch_pc;
   assign br_if.out_correct_address  = r_correct_address;
   assign br_if.out_branch_count     = r_branch_count;
   assign br_if.out_mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a cycle model pushes the expected output record each cycle
// and the record is popped and compared after the clock edge; key test-plan values are also
// checked against literal constants.
module tb_branch_resolver;
   localparam int unsigned FLUSH = 2;
   localparam int unsigned CW    = 4;

   typedef struct packed {
      logic          ready;
      logic          mis;
      logic          upd;
      logic          taken;
      logic [31:0]   pc;
      logic [31:0]   corr;
      logic [CW-1:0] bc;
      logic [CW-1:0] mc;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ena = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   rec_t q[$];
   rec_t m;
   int   m_fc = 0;

   always #5 clk = ~clk;

   branch_resolver_if #(.CNT_WIDTH(CW)) bus ();

   branch_resolver #(
      .FLUSH_CYCLES (FLUSH),
      .CNT_WIDTH    (CW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .br_if (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Model the coming edge, push the expectation, clock, then pop and compare.
   task automatic tick();
      rec_t        e;
      rec_t        got;
      logic        isj;
      logic        mis;
      logic [31:0] pc4;
      e     = m;
      e.mis = 1'b0;
      e.upd = 1'b0;
      if (rst) begin
         e       = '0;
         e.ready = 1'b1;
         m_fc    = 0;
      end else if (ena) begin
         if (m.ready) begin
            if (bus.in_commit_valid && (bus.in_commit_is_branch || bus.in_commit_is_jalr)) begin
               isj = bus.in_commit_is_jalr;
               pc4 = bus.in_commit_pc + 32'd4;
               if (isj) begin
                  e.taken = 1'b1;
                  e.corr  = bus.in_commit_target;
                  mis     = (bus.in_commit_target != pc4);
               end else begin
                  e.taken = bus.in_commit_actual_taken;
                  e.corr  = bus.in_commit_actual_taken ? bus.in_commit_target : pc4;
                  mis     = (bus.in_commit_pred_taken != bus.in_commit_actual_taken);
               end
               e.pc  = bus.in_commit_pc;
               e.upd = 1'b1;
               e.bc  = e.bc + 1'b1;
               if (mis) begin
                  e.mis   = 1'b1;
                  e.mc    = e.mc + 1'b1;
                  e.ready = 1'b0;
                  m_fc    = FLUSH;
               end
            end
         end else if (m_fc == 1) begin
            e.ready = 1'b1;
            m_fc    = 0;
         end else begin
            m_fc = m_fc - 1;
         end
      end
      q.push_back(e);
      m = e;
      @(posedge clk);
      #1;
      got = q.pop_front();
      chk("ready", bus.out_ready, got.ready);
      chk("misbranch", bus.out_misbranch, got.mis);
      chk("update_valid", bus.out_update_valid, got.upd);
      chk("taken", bus.out_branch_taken, got.taken);
      chk("branch_pc", bus.out_branch_pc, got.pc);
      chk("correct_addr", bus.out_correct_address, got.corr);
      chk("branch_count", 32'(bus.out_branch_count), 32'(got.bc));
      chk("mispredict_count", 32'(bus.out_mispredict_count), 32'(got.mc));
   endtask

   task automatic commit(input logic br, input logic jr, input logic [31:0] pc,
                         input logic pred, input logic act, input logic [31:0] tgt);
      bus.in_commit_valid        = 1'b1;
      bus.in_commit_is_branch    = br;
      bus.in_commit_is_jalr      = jr;
      bus.in_commit_pc           = pc;
      bus.in_commit_pred_taken   = pred;
      bus.in_commit_actual_taken = act;
      bus.in_commit_target       = tgt;
   endtask

   task automatic idle();
      bus.in_commit_valid = 1'b0;
   endtask

   initial begin
      commit(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      idle();
      // Reset
      rst = 1'b1;
      tick();
      tick();
      chk("rst_ready", bus.out_ready, 32'd1);
      chk("rst_bc", 32'(bus.out_branch_count), 32'd0);
      chk("rst_addr", bus.out_correct_address, 32'd0);
      rst = 1'b0;
      tick();

      // Correctly predicted not-taken branch
      commit(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h140);
      tick();
      idle();
      chk("corr_addr", bus.out_correct_address, 32'h104);
      chk("corr_upd", bus.out_update_valid, 32'd1);
      chk("corr_bc", 32'(bus.out_branch_count), 32'd1);

      // Mispredicted taken branch; a commit offered during the flush is ignored
      commit(1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h180);
      tick();
      chk("mis_pulse", bus.out_misbranch, 32'd1);
      chk("mis_addr", bus.out_correct_address, 32'h180);
      chk("mis_ready", bus.out_ready, 32'd0);
      commit(1'b1, 1'b0, 32'h900, 1'b0, 1'b0, 32'h0);
      tick();
      chk("flush1_ready", bus.out_ready, 32'd0);
      tick();
      chk("flush2_ready", bus.out_ready, 32'd1);
      chk("flush_bc", 32'(bus.out_branch_count), 32'd2);
      idle();
      tick();

      // JALR, predicted pc+4: hit then miss
      commit(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h304);
      tick();
      chk("jalr_taken", bus.out_branch_taken, 32'd1);
      chk("jalr_nomis", bus.out_misbranch, 32'd0);
      commit(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h400);
      tick();
      idle();
      chk("jalr_mis", bus.out_misbranch, 32'd1);
      chk("jalr_addr", bus.out_correct_address, 32'h400);
      // ena low in flush stretches the stall
      tick();
      ena = 1'b0;
      tick();
      chk("ena_hold_ready", bus.out_ready, 32'd0);
      ena = 1'b1;
      tick();
      chk("ena_release", bus.out_ready, 32'd1);

      // Both type flags set behaves as JALR
      commit(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h504);
      tick();
      chk("both_taken", bus.out_branch_taken, 32'd1);
      chk("both_nomis", bus.out_misbranch, 32'd0);

      // Non-control commit ignored; ena low blocks accept
      commit(1'b0, 1'b0, 32'h600, 1'b0, 1'b1, 32'h0);
      tick();
      commit(1'b1, 1'b0, 32'h700, 1'b0, 1'b0, 32'h0);
      ena = 1'b0;
      tick();
      ena = 1'b1;

      // pc+4 wraps
      commit(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h10);
      tick();
      chk("wrap_addr", bus.out_correct_address, 32'h0);
      chk("wrap_pc", bus.out_branch_pc, 32'hFFFF_FFFC);

      // Branch counter wrap via back-to-back correct predictions (6 so far)
      for (int i = 0; i < 10; i++) begin
         commit(1'b1, 1'b0, 32'h1000 + 32'(i * 4), 1'b1, 1'b1, 32'h2000);
         tick();
      end
      idle();
      chk("bc_wrap", 32'(bus.out_branch_count), 32'd0);

      // Mispredict counter wrap (2 so far)
      for (int i = 0; i < 14; i++) begin
         commit(1'b1, 1'b0, 32'h3000, 1'b1, 1'b0, 32'h3100);
         tick();
         idle();
         for (int k = 0; k < int'(FLUSH); k++) tick();
      end
      chk("mc_wrap", 32'(bus.out_mispredict_count), 32'd0);

      // Reset in the middle of a flush
      commit(1'b1, 1'b0, 32'h4000, 1'b0, 1'b1, 32'h4400);
      tick();
      idle();
      chk("pre_rst_ready", bus.out_ready, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", bus.out_ready, 32'd1);
      chk("midrst_mis", bus.out_misbranch, 32'd0);
      chk("midrst_mc", 32'(bus.out_mispredict_count), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
